memory_read_arbiter: RTL and testbench

- Shares one read port of a tri_port_memory instance between two requesters:
  - the VGA text/content fetcher (vga_controller side);
  - a CPU/debug reader.
- Pipelined, one grant per clock, fixed two-cycle read latency, tag-routed return data.
- During active video the VGA fetcher has priority. During blanking the CPU reader has priority.
- An optional starvation guard bounds CPU wait during active video.

---
 rtl/memory_read_arbiter.sv | 122 ++++++++++++
 tb/tb_memory_read_arbiter.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_read_arbiter.sv
// Two-requester arbiter for one pipelined memory read port: VGA fetcher vs CPU reader,
// mode-dependent priority, tag-routed return data. Optional CPU starvation guard: ARBITER_STARVE_GUARD_EN.
module memory_read_arbiter #(
   parameter int ADDRESS_WIDTH = 11,
   parameter int DATA_WIDTH    = 16,
   parameter int STARVE_LIMIT  = 8
) (
   input  logic                     clock_in,
   input  logic                     reset_n_in,
   input  logic                     display_on_in,
   input  logic                     vga_req_in,
   input  logic [ADDRESS_WIDTH-1:0] vga_address_in,
   output logic                     vga_ack_out,
   output logic [DATA_WIDTH-1:0]    vga_data_out,
   output logic                     vga_valid_out,
   input  logic                     cpu_req_in,
   input  logic [ADDRESS_WIDTH-1:0] cpu_address_in,
   output logic                     cpu_ack_out,
   output logic [DATA_WIDTH-1:0]    cpu_data_out,
   output logic                     cpu_valid_out,
   output logic [ADDRESS_WIDTH-1:0] memory_address_out,
   output logic                     memory_rd_out,
   input  logic [DATA_WIDTH-1:0]    memory_data_in
);

   // Handshake: a request is accepted in the cycle where req and ack are both high;
   // the requester holds req/address until it sees ack at a rising edge, and may drop req freely.

   localparam logic [0:0] MODE_CPU_PRIO = 1'b0;
   localparam logic [0:0] MODE_VGA_PRIO = 1'b1;

   generate
      if (STARVE_LIMIT < 1 || STARVE_LIMIT > 255) begin : g_bad_starve_limit
         $error("STARVE_LIMIT must be in 1..255");
      end
   endgenerate

   logic [0:0] mode;
   logic       force_cpu;
   logic       grant_vga;
   logic       grant_cpu;
   logic       issue_cpu;

   always_ff @(posedge clock_in or negedge reset_n_in) begin
      if (!reset_n_in) begin
         mode <= MODE_CPU_PRIO;
      end else begin
         mode <= display_on_in ? MODE_VGA_PRIO : MODE_CPU_PRIO;
      end
   end

`ifdef ARBITER_STARVE_GUARD_EN
   localparam logic [7:0] STARVE_LIMIT_8 = 8'(STARVE_LIMIT);
   logic [7:0] starve_count;

   assign force_cpu = (mode == MODE_VGA_PRIO) && cpu_req_in && (starve_count == STARVE_LIMIT_8);

   // Counts consecutive refused cycles of a pending CPU request during active video.
   always_ff @(posedge clock_in or negedge reset_n_in) begin
      if (!reset_n_in) begin
         starve_count <= 8'd0;
      end else if ((mode != MODE_VGA_PRIO) || !cpu_req_in || cpu_ack_out) begin
         starve_count <= 8'd0;
      end else if (starve_count != 8'hFF) begin
         starve_count <= starve_count + 8'd1;
      end
   end
`else
   assign force_cpu = 1'b0;
`endif

   always_comb begin
      grant_vga = 1'b0;
      grant_cpu = 1'b0;
      if (reset_n_in) begin
         if (mode == MODE_CPU_PRIO) begin
            grant_cpu = cpu_req_in;
            grant_vga = vga_req_in && !cpu_req_in;
         end else begin
            grant_vga = vga_req_in && !force_cpu;
            grant_cpu = cpu_req_in && (!vga_req_in || force_cpu);
         end
      end
   end

   assign vga_ack_out = grant_vga;
   assign cpu_ack_out = grant_cpu;

   // Issue stage: memory_rd_out doubles as the in-flight tag valid, issue_cpu as the owner.
   always_ff @(posedge clock_in or negedge reset_n_in) begin
      if (!reset_n_in) begin
         memory_address_out <= '0;
         memory_rd_out      <= 1'b0;
         issue_cpu          <= 1'b0;
      end else begin
         memory_rd_out <= grant_vga || grant_cpu;
         issue_cpu     <= grant_cpu;
         if (grant_vga || grant_cpu) begin
            memory_address_out <= grant_cpu ? cpu_address_in : vga_address_in;
         end
      end
   end

   always_ff @(posedge clock_in or negedge reset_n_in) begin
      if (!reset_n_in) begin
         vga_data_out  <= '0;
         vga_valid_out <= 1'b0;
         cpu_data_out  <= '0;
         cpu_valid_out <= 1'b0;
      end else begin
         vga_valid_out <= memory_rd_out && !issue_cpu;
         cpu_valid_out <= memory_rd_out && issue_cpu;
         if (memory_rd_out && !issue_cpu) begin
            vga_data_out <= memory_data_in;
         end
         if (memory_rd_out && issue_cpu) begin
            cpu_data_out <= memory_data_in;
         end
      end
   end

endmodule

// File: tb/tb_memory_read_arbiter.sv
// Randomized bench for memory_read_arbiter against a cycle-indexed reference model
// (priority rules + result queue keyed by due cycle). Build with ARBITER_STARVE_GUARD_EN for the guard variant.
module tb_memory_read_arbiter;

   localparam int AW    = 11;
   localparam int DW    = 16;
   localparam int LIMIT = 8;
`ifdef ARBITER_STARVE_GUARD_EN
   localparam bit GUARD = 1'b1;
`else
   localparam bit GUARD = 1'b0;
`endif

   logic          clock_in;
   logic          reset_n_in;
   logic          display_on_in;
   logic          vga_req_in;
   logic [AW-1:0] vga_address_in;
   logic          vga_ack_out;
   logic [DW-1:0] vga_data_out;
   logic          vga_valid_out;
   logic          cpu_req_in;
   logic [AW-1:0] cpu_address_in;
   logic          cpu_ack_out;
   logic [DW-1:0] cpu_data_out;
   logic          cpu_valid_out;
   logic [AW-1:0] memory_address_out;
   logic          memory_rd_out;
   logic [DW-1:0] memory_data_in;

   memory_read_arbiter #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .STARVE_LIMIT(LIMIT)) dut (
      .clock_in           (clock_in),
      .reset_n_in         (reset_n_in),
      .display_on_in      (display_on_in),
      .vga_req_in         (vga_req_in),
      .vga_address_in     (vga_address_in),
      .vga_ack_out        (vga_ack_out),
      .vga_data_out       (vga_data_out),
      .vga_valid_out      (vga_valid_out),
      .cpu_req_in         (cpu_req_in),
      .cpu_address_in     (cpu_address_in),
      .cpu_ack_out        (cpu_ack_out),
      .cpu_data_out       (cpu_data_out),
      .cpu_valid_out      (cpu_valid_out),
      .memory_address_out (memory_address_out),
      .memory_rd_out      (memory_rd_out),
      .memory_data_in     (memory_data_in)
   );

   // clock / reset block
   initial clock_in = 1'b0;
   always #5 clock_in = ~clock_in;

   // memory read port clocked on the inverted clock
   logic [DW-1:0] mem [0:(1<<AW)-1];
   always @(negedge clock_in) memory_data_in <= mem[memory_address_out];

   typedef struct {
      int          due;
      bit          cpu;
      logic [DW-1:0] data;
   } exp_t;

   exp_t          exp_q[$];
   int            checks   = 0;
   int            failures = 0;
   int            cyc      = 0;
   bit            m_vga_prio;
   int            m_wait;
   logic [AW-1:0] m_addr;
   bit            m_rd;
   logic [DW-1:0] m_vga_data;
   logic [DW-1:0] m_cpu_data;
   int            n_vga_ack, n_cpu_ack, n_vga_valid;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s cycle=%0d got=%0h exp=%0h", tag, cyc, got, exp);
      end
   endtask

   // 0 = nobody, 1 = VGA, 2 = CPU
   function automatic int model_winner(input bit vreq, input bit creq);
      if (!m_vga_prio) return creq ? 2 : (vreq ? 1 : 0);
      if (creq && (!vreq || (GUARD && m_wait == LIMIT))) return 2;
      return vreq ? 1 : 0;
   endfunction

   task automatic model_reset();
      exp_q.delete();
      m_vga_prio = 1'b0;
      m_wait     = 0;
      m_addr     = '0;
      m_rd       = 1'b0;
      m_vga_data = '0;
      m_cpu_data = '0;
   endtask

   task automatic check_outputs();
      exp_t e;
      bit   ev = 1'b0;
      bit   ec = 1'b0;
      if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
         e = exp_q.pop_front();
         if (e.cpu) begin ec = 1'b1; m_cpu_data = e.data; end
         else       begin ev = 1'b1; m_vga_data = e.data; end
      end
      if (vga_valid_out) n_vga_valid++;
      check("vga_valid", vga_valid_out, ev);
      check("cpu_valid", cpu_valid_out, ec);
      check("vga_data", vga_data_out, m_vga_data);
      check("cpu_data", cpu_data_out, m_cpu_data);
      check("mem_rd", memory_rd_out, m_rd);
      check("mem_addr", memory_address_out, m_addr);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_vga_ack"}, vga_ack_out, 0);
      check({tag, "_cpu_ack"}, cpu_ack_out, 0);
      check({tag, "_outs"}, {vga_valid_out, cpu_valid_out, memory_rd_out}, 0);
      check({tag, "_vga_data"}, vga_data_out, 0);
      check({tag, "_cpu_data"}, cpu_data_out, 0);
      check({tag, "_mem_addr"}, memory_address_out, 0);
   endtask

   // driver: called at posedge+1, applies one cycle of inputs and checks the result
   task automatic cycle(input bit disp, input bit vreq, input logic [AW-1:0] vaddr,
                        input bit creq, input logic [AW-1:0] caddr);
      int w;
      display_on_in  = disp;
      vga_req_in     = vreq;
      vga_address_in = vaddr;
      cpu_req_in     = creq;
      cpu_address_in = caddr;
      #1;
      w = model_winner(vreq, creq);
      check("vga_ack", vga_ack_out, (w == 1));
      check("cpu_ack", cpu_ack_out, (w == 2));
      if (vga_ack_out) n_vga_ack++;
      if (cpu_ack_out) n_cpu_ack++;
      if (w != 0) begin
         m_addr = (w == 2) ? caddr : vaddr;
         exp_q.push_back('{due: cyc + 2, cpu: (w == 2), data: mem[m_addr]});
      end
      m_rd = (w != 0);
      if (m_vga_prio && creq && w != 2) m_wait++;
      else m_wait = 0;
      @(posedge clock_in);
      #1;
      cyc++;
      m_vga_prio = disp;
      check_outputs();
   endtask

   task automatic idle(input bit disp, input int n);
      for (int i = 0; i < n; i++) cycle(disp, 1'b0, '0, 1'b0, '0);
   endtask

   // asserts reset with both requests active, holds it, releases at posedge+1
   task automatic do_reset();
      vga_req_in     = 1'b1;
      cpu_req_in     = 1'b1;
      vga_address_in = AW'($urandom_range(0, (1<<AW)-1));
      cpu_address_in = AW'($urandom_range(0, (1<<AW)-1));
      reset_n_in     = 1'b0;
      #1;
      model_reset();
      check_all_zero("rst");
      for (int i = 0; i < 2; i++) begin
         @(posedge clock_in);
         #1;
         cyc++;
         check_all_zero("rst_hold");
      end
      vga_req_in = 1'b0;
      cpu_req_in = 1'b0;
      reset_n_in = 1'b1;
   endtask

   initial begin
      bit disp;
      reset_n_in     = 1'b0;
      display_on_in  = 1'b0;
      vga_req_in     = 1'b0;
      cpu_req_in     = 1'b0;
      vga_address_in = '0;
      cpu_address_in = '0;
      for (int i = 0; i < (1<<AW); i++) mem[i] = DW'($urandom);
      mem[5] = 16'h000B;
      #1;
      do_reset();

      // first CPU read after reset
      cycle(1'b0, 1'b0, '0, 1'b1, 11'h005);
      idle(1'b0, 3);

      // back-to-back VGA reads
      for (int i = 0; i < 10; i++) mem[i] = DW'(2 * i);
      idle(1'b1, 1);
      n_vga_ack   = 0;
      n_vga_valid = 0;
      for (int i = 0; i < 10; i++) cycle(1'b1, 1'b1, AW'(i), 1'b0, '0);
      idle(1'b1, 3);
      check("b2b_vga_acks", n_vga_ack, 10);
      check("b2b_vga_valids", n_vga_valid, 10);

      // contention during active video
      n_vga_ack = 0;
      n_cpu_ack = 0;
      for (int i = 0; i < 20; i++)
         cycle(1'b1, 1'b1, AW'($urandom_range(0, 2047)), 1'b1, AW'($urandom_range(0, 2047)));
      idle(1'b1, 3);
      check("vprio_vga_acks", n_vga_ack, GUARD ? 18 : 20);
      check("vprio_cpu_acks", n_cpu_ack, GUARD ? 2 : 0);

      // contention during blanking, then CPU drops out
      idle(1'b0, 1);
      n_vga_ack = 0;
      n_cpu_ack = 0;
      for (int i = 0; i < 6; i++)
         cycle(1'b0, 1'b1, AW'($urandom_range(0, 2047)), 1'b1, AW'($urandom_range(0, 2047)));
      for (int i = 0; i < 3; i++)
         cycle(1'b0, 1'b1, AW'($urandom_range(0, 2047)), 1'b0, '0);
      idle(1'b0, 3);
      check("cprio_cpu_acks", n_cpu_ack, 6);
      check("cprio_vga_acks", n_vga_ack, 3);

      // reset one cycle after a VGA ack: the in-flight read must vanish
      idle(1'b1, 1);
      cycle(1'b1, 1'b1, 11'h123, 1'b0, '0);
      do_reset();
      n_vga_valid = 0;
      idle(1'b0, 4);
      check("midreset_no_valid", n_vga_valid, 0);

      // randomized traffic
      disp = 1'b0;
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 24) == 0) disp = ~disp;
         cycle(disp, ($urandom_range(0, 3) != 0), AW'($urandom_range(0, 2047)),
               ($urandom_range(0, 2) != 0), AW'($urandom_range(0, 2047)));
      end
      idle(1'b0, 3);
      check("final_queue_empty", exp_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
